// File: rtl/spi_mem_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the SPI memory controller.
// Bit 24 of the request address picks the chip; the low 24 bits go on the wire.
package spi_mem_ctrl_pkg;

  localparam logic [7:0] READ_CMD     = 8'h03;
  localparam logic [7:0] WRITE_CMD    = 8'h02;
  localparam int         ADDR_W       = 25;
  localparam int         CHIP_SEL_BIT = 24;
  localparam logic       CHIP_FLASH   = 1'b0;
  localparam logic       CHIP_SRAM    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_END,
    ST_DONE
  } state_e;

  function automatic logic nb_legal(input logic [2:0] nb);
    return (nb == 3'd1) || (nb == 3'd2) || (nb == 3'd4);
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Request/response bus from the core plus the SPI pins of the memory controller.
// The controller uses the slave modport, the core (or a bench) the master one.
interface spi_mem_ctrl_if;
  import spi_mem_ctrl_pkg::*;

  logic              start_request;
  logic              is_write;
  logic [2:0]        num_bytes;
  logic [ADDR_W-1:0] target_address;
  logic [31:0]       write_value;
  logic [31:0]       fetched_data;
  logic              request_done;
  logic              sclk;
  logic              mosi;
  logic              cs1;
  logic              cs2;
  logic              miso;

  modport master (
    output start_request, is_write, num_bytes, target_address, write_value, miso,
    input  fetched_data, request_done, sclk, mosi, cs1, cs2
  );

  modport slave (
    input  start_request, is_write, num_bytes, target_address, write_value, miso,
    output fetched_data, request_done, sclk, mosi, cs1, cs2
  );

endinterface

// File: rtl/spi_mem_ctrl_bit_engine.sv
// Two-phase SPI bit engine: shifts out len_i bits of tx_word_i MSB first,
// samples miso on the edge that raises sclk, and strobes at field/byte ends.
module spi_mem_ctrl_bit_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [5:0]  len_i,
  input  logic [31:0] tx_word_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        bit_done_o,
  output logic        byte_done_o,
  output logic [7:0]  rx_byte_o
);

  logic        busy_q, busy_d;
  logic        phase_q, phase_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;

  // A load on the last phase-1 cycle chains the next field with no gap.
  always_comb begin
    busy_d  = busy_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    if (load_i) begin
      busy_d  = 1'b1;
      phase_d = 1'b0;
      cnt_d   = len_i;
      tx_d    = tx_word_i;
    end else if (busy_q) begin
      if (!phase_q) begin
        phase_d = 1'b1;
        rx_d    = {rx_q[6:0], miso_i};
      end else begin
        phase_d = 1'b0;
        tx_d    = {tx_q[30:0], 1'b0};
        cnt_d   = cnt_q - 6'd1;
        if (cnt_q == 6'd1) busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  assign sclk_o      = busy_q & phase_q;
  assign mosi_o      = busy_q & tx_q[31];
  assign bit_done_o  = busy_q & phase_q & (cnt_q == 6'd1);
  assign byte_done_o = busy_q & phase_q & (cnt_q[2:0] == 3'd1);
  assign rx_byte_o   = rx_q;

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI master for flash (cs1, read-only) and SPI SRAM (cs2): one 1/2/4-byte
// READ 0x03 / WRITE 0x02 transaction with a 24-bit address per request.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | wait for start_request, latch request
// SEL     | selected CS low, sclk low, load command byte
// CMD     | shifting 8-bit opcode
// ADDR    | shifting 24-bit address, addr[23] first
// DATA    | shifting 8*num_bytes data bits (tx or rx)
// END     | CS released
// DONE    | request_done while start_request held; back to IDLE on drop
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  spi_mem_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [2:0]        nb_q, nb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       fetched_q, fetched_d;

  logic        eng_load;
  logic [5:0]  eng_len;
  logic [31:0] eng_tx;
  logic        bit_done, byte_done;
  logic [7:0]  rx_byte;
  logic        cs_active;

  spi_mem_ctrl_bit_engine u_bit_engine (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (eng_load),
    .len_i       (eng_len),
    .tx_word_i   (eng_tx),
    .miso_i      (bus.miso),
    .sclk_o      (bus.sclk),
    .mosi_o      (bus.mosi),
    .bit_done_o  (bit_done),
    .byte_done_o (byte_done),
    .rx_byte_o   (rx_byte)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    nb_d      = nb_q;
    wdata_d   = wdata_q;
    fetched_d = fetched_q;
    eng_load  = 1'b0;
    eng_len   = '0;
    eng_tx    = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_request) begin
          addr_d  = bus.target_address;
          wr_d    = bus.is_write;
          nb_d    = bus.num_bytes;
          wdata_d = bus.write_value;
          if (!bus.is_write) fetched_d = '0;
          // Flash is never written; bad sizes are acknowledged without a transfer.
          if (!nb_legal(bus.num_bytes) ||
              (bus.is_write && (bus.target_address[CHIP_SEL_BIT] == CHIP_FLASH)))
            state_d = ST_DONE;
          else
            state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        eng_load = 1'b1;
        eng_len  = 6'd8;
        eng_tx   = {(wr_q ? WRITE_CMD : READ_CMD), 24'h000000};
        state_d  = ST_CMD;
      end
      ST_CMD: begin
        if (bit_done) begin
          eng_load = 1'b1;
          eng_len  = 6'd24;
          eng_tx   = {addr_q[23:0], 8'h00};
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bit_done) begin
          eng_load = 1'b1;
          eng_len  = {nb_q, 3'b000};
          // Little-endian store: byte 0 leaves first, each byte MSB first.
          eng_tx   = wr_q ? {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]}
                          : 32'h0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_done && !wr_q) fetched_d = {rx_byte, fetched_q[31:8]};
        if (bit_done) state_d = ST_END;
      end
      ST_END:  state_d = ST_DONE;
      ST_DONE: if (!bus.start_request) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      nb_q      <= '0;
      wdata_q   <= '0;
      fetched_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      nb_q      <= nb_d;
      wdata_q   <= wdata_d;
      fetched_q <= fetched_d;
    end
  end

  assign cs_active        = (state_q == ST_SEL) || (state_q == ST_CMD) ||
                            (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign bus.cs1          = !(cs_active && (addr_q[CHIP_SEL_BIT] == CHIP_FLASH));
  assign bus.cs2          = !(cs_active && (addr_q[CHIP_SEL_BIT] == CHIP_SRAM));
  assign bus.request_done = (state_q == ST_DONE) && bus.start_request;
  assign bus.fetched_data = fetched_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: a small SPI slave model logs mosi and
// serves miso, each request is checked against hand-computed values.
module tb_spi_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_ctrl_if bus();

  spi_mem_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model, evaluated mid-cycle while all DUT outputs are stable.
  logic [63:0] mosi_log  = '0;
  logic [63:0] rx_bits   = '0;
  logic [5:0]  bitcnt    = '0;
  logic        prev_sclk = 1'b0;
  int cs1_cyc = 0, cs2_cyc = 0, both_cyc = 0, rises = 0;

  always @(negedge clk) begin
    if (bus.cs1 && bus.cs2) begin
      bitcnt = '0;
    end else if (bus.sclk && !prev_sclk) begin
      mosi_log = {mosi_log[62:0], bus.mosi};
      bitcnt   = bitcnt + 6'd1;
      rises++;
    end
    prev_sclk = bus.sclk;
    if (!bus.cs1) cs1_cyc++;
    if (!bus.cs2) cs2_cyc++;
    if (!bus.cs1 && !bus.cs2) both_cyc++;
    bus.miso = rx_bits[~bitcnt];
  end

  task automatic run_req(input string tag, input logic wr, input logic [2:0] nb,
                         input logic [24:0] addr, input logic [31:0] wdata,
                         input logic [63:0] rx, input int exp_lat, input int exp_bits,
                         input logic [63:0] exp_log, input int exp_cs,
                         input logic [31:0] exp_fd, input int hold);
    int n, c1, c2, cb, r;
    logic [63:0] mask;
    @(posedge clk); #1;
    c1 = cs1_cyc; c2 = cs2_cyc; cb = both_cyc; r = rises;
    rx_bits                = rx;
    bus.is_write           = wr;
    bus.num_bytes          = nb;
    bus.target_address     = addr;
    bus.write_value        = wdata;
    bus.start_request      = 1'b1;
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        bus.target_address = ~addr;
        bus.is_write       = ~wr;
        bus.num_bytes      = 3'd0;
        bus.write_value    = ~wdata;
      end
      if (bus.request_done) break;
    end
    chk($sformatf("%s latency", tag), 64'(n), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s hold", tag), 64'(bus.request_done), 64'd1);
    end
    bus.start_request = 1'b0;
    #1;
    chk($sformatf("%s done drop", tag), 64'(bus.request_done), 64'd0);
    chk($sformatf("%s fetched", tag), 64'(bus.fetched_data), 64'(exp_fd));
    chk($sformatf("%s sclk bits", tag), 64'(rises - r), 64'(exp_bits));
    if (exp_bits > 0) begin
      mask = (exp_bits >= 64) ? '1 : ((64'd1 << exp_bits) - 64'd1);
      chk($sformatf("%s mosi", tag), mosi_log & mask, exp_log);
    end
    chk($sformatf("%s cs1 used", tag), 64'((cs1_cyc - c1) != 0), 64'(exp_cs == 1));
    chk($sformatf("%s cs2 used", tag), 64'((cs2_cyc - c2) != 0), 64'(exp_cs == 2));
    chk($sformatf("%s both cs low", tag), 64'(both_cyc - cb), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, done_seen;
    bus.start_request  = 1'b0;
    bus.is_write       = 1'b0;
    bus.num_bytes      = 3'd0;
    bus.target_address = '0;
    bus.write_value    = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cs1", 64'(bus.cs1), 64'd1);
    chk("reset cs2", 64'(bus.cs2), 64'd1);
    chk("reset sclk", 64'(bus.sclk), 64'd0);
    chk("reset mosi", 64'(bus.mosi), 64'd0);
    chk("reset done", 64'(bus.request_done), 64'd0);
    chk("reset fetched", 64'(bus.fetched_data), 64'd0);
    rst_n = 1'b1;

    run_req("rd4 flash", 1'b0, 3'd4, 25'h0000010, 32'h0, {32'h0, 32'h13055000},
            131, 64, 64'h0300_0010_0000_0000, 1, 32'h00500513, 5);
    run_req("rd1 sram", 1'b0, 3'd1, 25'h10000FF, 32'h0, {32'h0, 32'hA5000000},
            83, 40, 64'h0000_0003_0000_FF00, 2, 32'hA5000000, 0);
    run_req("wr2 sram", 1'b1, 3'd2, 25'h1000004, 32'h0000BEEF, '1,
            99, 48, 64'h0000_0200_0004_EFBE, 2, 32'hA5000000, 0);
    run_req("wr flash", 1'b1, 3'd4, 25'h0000020, 32'h12345678, '1,
            1, 0, 64'h0, 0, 32'hA5000000, 0);
    run_req("rd3 illegal", 1'b0, 3'd3, 25'h1000000, 32'h0, '1,
            1, 0, 64'h0, 0, 32'h0, 0);

    // Request withdrawn mid-transfer: transfer completes, done never shows.
    @(posedge clk); #1;
    r = rises;
    done_seen = 0;
    rx_bits = {32'h0, 32'h3C000000};
    bus.is_write = 1'b0; bus.num_bytes = 3'd1; bus.target_address = 25'h1000040;
    bus.start_request = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    bus.start_request = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.request_done) done_seen++;
    end
    chk("mid drop done seen", 64'(done_seen), 64'd0);
    chk("mid drop sclk bits", 64'(rises - r), 64'd40);
    chk("mid drop fetched", 64'(bus.fetched_data), 64'hA5000000 ^ 64'h99000000);

    // Reset while the address phase is at address bit 20 (overall bit 28).
    @(posedge clk); #1;
    r = rises;
    rx_bits = {32'h0, 32'h13055000};
    bus.is_write = 1'b0; bus.num_bytes = 3'd4; bus.target_address = 25'h0000010;
    bus.start_request = 1'b1;
    repeat (58) begin @(posedge clk); #1; end
    chk("pre-reset sclk bits", 64'(rises - r), 64'd28);
    chk("pre-reset cs1", 64'(bus.cs1), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort cs1", 64'(bus.cs1), 64'd1);
    chk("abort cs2", 64'(bus.cs2), 64'd1);
    chk("abort sclk", 64'(bus.sclk), 64'd0);
    chk("abort done", 64'(bus.request_done), 64'd0);
    bus.start_request = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_req("rd4 after reset", 1'b0, 3'd4, 25'h0000010, 32'h0, {32'h0, 32'h13055000},
            131, 64, 64'h0300_0010_0000_0000, 1, 32'h00500513, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
